// File: rtl/pio_input_irq_pkg.sv
// Shared constants for the PIO input block: register offsets, edge
// selection codes and the debounce counter width helper.
package pio_input_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Counter must be able to hold DEBOUNCE_CYCLES; never narrower than 1 bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pio_input_irq_if.sv
// Avalon-MM slave bus bundle for the PIO input block.
// Handshake: a write is accepted on the clk edge where chipselect=1 and
// write_n=0; reads need no strobe, readdata reflects address one cycle later.
interface pio_input_irq_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pio_debounce_bit.sv
// One input bit: SYNC_STAGES-deep synchroniser followed by an optional
// debounce filter that only accepts a level held for DEBOUNCE_CYCLES cycles.
module pio_debounce_bit
    import pio_input_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    output logic o_stable
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign o_stable = w_sync;
    end else begin : g_debounce
        localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
        localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

        logic [CW-1:0] r_cnt;
        logic          r_stable;

        // Any return to the accepted level restarts the count, so short glitches never land.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (w_sync != r_stable) begin
                if (r_cnt == CNT_LAST) begin
                    r_stable <= w_sync;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign o_stable = r_stable;
    end

endmodule

// File: rtl/pio_input_irq.sv
// PIO input port with edge capture and masked level interrupt.
// Per-bit conditioning lives in pio_debounce_bit; this level owns the registers.
module pio_input_irq
    import pio_input_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = EDGE_RISING
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_input_irq_if.slave       bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_wr;
    logic             w_unused;
    logic [31:0]      w_rdata;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      r_readdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        pio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_in     (in_port[g]),
            .o_stable (w_stable[g])
        );
    end

    assign w_wr     = bus.chipselect & ~bus.write_n;
    assign w_wdata  = bus.writedata[WIDTH-1:0];
    assign w_unused = ^bus.writedata;
    assign w_clr    = (w_wr && bus.address == ADDR_EDGECAP) ? w_wdata : '0;

    always_comb begin
        w_edge = w_stable ^ r_prev;
        if (EDGE_TYPE == EDGE_RISING) begin
            w_edge = w_stable & ~r_prev;
        end else if (EDGE_TYPE == EDGE_FALLING) begin
            w_edge = ~w_stable & r_prev;
        end
    end

    // Edge is OR-ed in after the W1C mask so a coincident edge survives the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev    <= '0;
            r_mask    <= '0;
            r_edgecap <= '0;
        end else begin
            r_prev    <= w_stable;
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
            if (w_wr && bus.address == ADDR_IRQMASK) begin
                r_mask <= w_wdata;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_DATA:    w_rdata[WIDTH-1:0] = w_stable;
            ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_mask;
            ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_edgecap;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = |(r_edgecap & r_mask);

endmodule

// File: tb/tb_pio_input_irq.sv
// Bench for pio_input_irq: an 8-bit debounced rising-edge instance and a
// 32-bit bypassed any-edge instance, with a read scoreboard and a model.
module tb_pio_input_irq;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_RSVD = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_ECAP = 2'd3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_a = 8'h00;
    logic [31:0] in_b = 32'h0;
    logic        irq_a;
    logic        irq_b;

    always #5 clk = ~clk;

    pio_input_irq_if bus_a ();
    pio_input_irq_if bus_b ();

    pio_input_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.slave), .in_port(in_a), .irq(irq_a)
    );

    pio_input_irq #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.slave), .in_port(in_b), .irq(irq_b)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        rd_go   = 1'b0;
    logic        rd_sel  = 1'b0;

    logic        mon_sel;
    logic [31:0] mon_exp;
    logic [31:0] mon_act;
    string       mon_name;

    always @(posedge clk) begin
        if (rd_go) begin
            mon_sel = rd_sel;
            #1;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL read_unexpected: no expected value queued");
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                mon_act  = mon_sel ? bus_b.readdata : bus_a.readdata;
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL %s: got %08h expected %08h", mon_name, mon_act, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- drivers (called at negedge) ----------------
    task automatic do_read(input bit sel, input logic [1:0] addr, input logic [31:0] exp,
                           input string name);
        if (sel) bus_b.address = addr;
        else     bus_a.address = addr;
        rd_sel = sel;
        rd_go  = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        rd_go = 1'b0;
    endtask

    task automatic do_write(input bit sel, input logic [1:0] addr, input logic [31:0] data);
        if (sel) begin
            bus_b.address = addr; bus_b.writedata = data;
            bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
        end else begin
            bus_a.address = addr; bus_a.writedata = data;
            bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        end
        @(negedge clk);
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
        bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
    endtask

    // ---------------- reference model for dut_a (settled levels) ----------------
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_edge = 8'h00;
    logic [7:0] m_mask = 8'h00;

    task automatic apply_in_a(input logic [7:0] v);
        in_a = v;
        repeat (10) @(negedge clk);
        m_edge = m_edge | (v & ~m_data);
        m_data = v;
    endtask

    task automatic wr_mask_a(input logic [31:0] v);
        do_write(1'b0, A_MASK, v);
        m_mask = v[7:0];
    endtask

    task automatic w1c_a(input logic [31:0] v);
        do_write(1'b0, A_ECAP, v);
        m_edge = m_edge & ~v[7:0];
    endtask

    task automatic check_all_a(input string tag);
        do_read(1'b0, A_DATA, {24'h0, m_data}, {tag, "_data"});
        do_read(1'b0, A_ECAP, {24'h0, m_edge}, {tag, "_edgecap"});
        do_read(1'b0, A_MASK, {24'h0, m_mask}, {tag, "_irqmask"});
        do_read(1'b0, A_RSVD, 32'h0, {tag, "_rsvd"});
        check({tag, "_irq"}, {31'h0, irq_a}, {31'h0, |(m_edge & m_mask)});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus_a.address = 2'd0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
        bus_b.address = 2'd0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
        in_a = 8'hFF;

        repeat (3) @(negedge clk);
        check("reset_readdata_a", bus_a.readdata, 32'h0);
        check("reset_irq_a", {31'h0, irq_a}, 32'h0);
        check("reset_readdata_b", bus_b.readdata, 32'h0);
        check("reset_irq_b", {31'h0, irq_b}, 32'h0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Post-reset 0->1 on stable is a genuine rising edge, so every bit is captured.
        m_data = 8'hFF; m_edge = 8'hFF; m_mask = 8'h00;
        check_all_a("after_reset");
        w1c_a(32'h0000_00FF);
        check_all_a("after_reset_clear");

        // Randomised phase against the model.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: apply_in_a(8'($urandom));
                1: wr_mask_a($urandom);
                2: w1c_a($urandom);
                default: do_write(1'b0, A_RSVD, $urandom);
            endcase
            check_all_a($sformatf("rand%0d", i));
        end

        apply_in_a(8'h00);
        wr_mask_a(32'h0);
        w1c_a(32'hFFFF_FFFF);
        check_all_a("normalised");

        // Glitch of 3 cycles on bit 0 is rejected.
        in_a = 8'h01;
        repeat (3) @(negedge clk);
        in_a = 8'h00;
        repeat (10) @(negedge clk);
        do_read(1'b0, A_DATA, 32'h0, "glitch_data");
        do_read(1'b0, A_ECAP, 32'h0, "glitch_edgecap");

        // Held level: DATA after SYNC+DEBOUNCE cycles, EDGECAP one cycle later.
        in_a = 8'h01;
        for (int k = 0; k < 6; k++) do_read(1'b0, A_DATA, 32'h0, $sformatf("latency_data_early%0d", k));
        do_read(1'b0, A_DATA, 32'h01, "latency_data");
        do_read(1'b0, A_ECAP, 32'h01, "latency_edgecap");
        do_write(1'b0, A_ECAP, 32'h01);
        in_a = 8'h00;
        repeat (10) @(negedge clk);

        // Interrupt flow on bit 2.
        do_write(1'b0, A_MASK, 32'h04);
        in_a = 8'h04;
        repeat (10) @(negedge clk);
        check("irq_flow_set", {31'h0, irq_a}, 32'h1);
        do_write(1'b0, A_ECAP, 32'h04);
        check("irq_flow_clear", {31'h0, irq_a}, 32'h0);
        do_read(1'b0, A_ECAP, 32'h0, "irq_flow_edgecap");

        // Masked edge on bit 5, then unmask.
        do_write(1'b0, A_MASK, 32'h0);
        in_a = 8'h24;
        repeat (10) @(negedge clk);
        do_read(1'b0, A_ECAP, 32'h20, "masked_edgecap");
        check("masked_irq_low", {31'h0, irq_a}, 32'h0);
        do_write(1'b0, A_MASK, 32'h20);
        check("unmasked_irq_high", {31'h0, irq_a}, 32'h1);
        do_read(1'b0, A_MASK, 32'h20, "unmasked_irqmask");

        // Set/clear collision on bit 1: edge lands on the same edge as the W1C.
        in_a = 8'h26;
        repeat (10) @(negedge clk);
        do_read(1'b0, A_ECAP, 32'h22, "collision_pre");
        in_a = 8'h24;
        repeat (10) @(negedge clk);
        in_a = 8'h26;
        repeat (6) @(negedge clk);
        do_write(1'b0, A_ECAP, 32'h02);
        do_read(1'b0, A_ECAP, 32'h22, "collision_set_wins");
        do_write(1'b0, A_ECAP, 32'h02);
        do_read(1'b0, A_ECAP, 32'h20, "w1c_plain");

        // 32-bit any-edge instance, no debounce: DATA after SYNC cycles.
        in_b = 32'h0000_0001;
        do_read(1'b1, A_DATA, 32'h0, "b_latency0");
        do_read(1'b1, A_DATA, 32'h0, "b_latency1");
        do_read(1'b1, A_DATA, 32'h1, "b_latency_data");
        do_read(1'b1, A_ECAP, 32'h1, "b_latency_edgecap");
        do_write(1'b1, A_ECAP, 32'h1);
        in_b = 32'h8000_0001;
        repeat (6) @(negedge clk);
        do_read(1'b1, A_ECAP, 32'h8000_0000, "b_rise31");
        do_write(1'b1, A_ECAP, 32'hFFFF_FFFF);
        in_b = 32'h0000_0001;
        repeat (6) @(negedge clk);
        do_read(1'b1, A_ECAP, 32'h8000_0000, "b_fall31");
        do_read(1'b1, A_DATA, 32'h0000_0001, "b_data");
        do_write(1'b1, A_RSVD, 32'hFFFF_FFFF);
        do_read(1'b1, A_RSVD, 32'h0, "b_rsvd");
        do_read(1'b1, A_ECAP, 32'h8000_0000, "b_rsvd_no_effect_ecap");
        do_read(1'b1, A_MASK, 32'h0, "b_rsvd_no_effect_mask");
        check("b_irq_low", {31'h0, irq_b}, 32'h0);
        do_write(1'b1, A_MASK, 32'hFFFF_FFFF);
        check("b_irq_high", {31'h0, irq_b}, 32'h1);
        do_read(1'b1, A_MASK, 32'hFFFF_FFFF, "b_mask_full");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d reads left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
